// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer
// Times debounced key press/release durations against a free-running
// prescaled tick and emits Morse symbols (dot, dash, letter gap, word gap)
// through a 4-entry valid/ready FIFO.
//
// Build option: define MORSE_WORD_GAP_EN to enable the LETTER state and
// word-gap symbols (code 11). Without it the FSM returns to IDLE right after
// the letter gap and code 11 is never produced.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | key released, no gap timing pending
// PRESS  | key held, timing the press to classify dot/dash
// GAP    | key released after a press, timing toward a letter gap
// LETTER | letter gap emitted, timing toward a word gap (word-gap build)

module morse_key_sequencer #(
    parameter int TICK_DIV = 27000,
    parameter int CNT_W    = 12,
    parameter int DASH_T   = 240,
    parameter int LETTER_T = 240,
    parameter int WORD_T   = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    input  logic       sym_ready,
    output logic       sym_valid,
    output logic [1:0] sym_code,
    output logic       pressed,
    output logic       overflow
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DUR_MAX  = '1;
    localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_T);
    localparam logic [CNT_W-1:0] LETTER_C = CNT_W'(LETTER_T);
`ifdef MORSE_WORD_GAP_EN
    localparam logic [CNT_W-1:0] WORD_C   = CNT_W'(WORD_T);
`endif

    localparam logic [1:0] SYM_DOT    = 2'b00;
    localparam logic [1:0] SYM_DASH   = 2'b01;
    localparam logic [1:0] SYM_LETTER = 2'b10;
`ifdef MORSE_WORD_GAP_EN
    localparam logic [1:0] SYM_WORD   = 2'b11;
`endif

    // A word gap must come strictly after the letter gap it follows.
    if (WORD_T <= LETTER_T) begin : g_bad_word_t
        $error("morse_key_sequencer: WORD_T must exceed LETTER_T");
    end

`ifdef MORSE_WORD_GAP_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        GAP    = 2'd2,
        LETTER = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        GAP    = 2'd2
    } state_t;
`endif

    state_t           state_q;
    state_t           state_d;

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic             key_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] dur_inc;

    logic             push;
    logic [1:0]       push_code;

    logic [1:0]       fifo_mem [4];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign tick    = (pre_cnt == PRE_MAX);
    assign rise    = key & ~key_q;
    assign fall    = ~key & key_q;
    assign dur_inc = dur + CNT_W'(1);

    // Free-running prescaler; key activity never realigns its phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Registered key copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key;
        end
    end

    // Duration in ticks since the last state change, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur <= '0;
        end else if (state_d != state_q) begin
            dur <= '0;
        end else if (tick && (dur != DUR_MAX)) begin
            dur <= dur_inc;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and symbol push; a key edge always beats a gap threshold.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_code = SYM_DOT;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (fall) begin
                    push      = 1'b1;
                    push_code = (dur < DASH_C) ? SYM_DOT : SYM_DASH;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = PRESS;
                end else if (tick && (dur_inc == LETTER_C)) begin
                    push      = 1'b1;
                    push_code = SYM_LETTER;
`ifdef MORSE_WORD_GAP_EN
                    state_d   = LETTER;
`else
                    state_d   = IDLE;
`endif
                end
            end
`ifdef MORSE_WORD_GAP_EN
            LETTER: begin
                if (rise) begin
                    state_d = PRESS;
                end else if (tick && (dur_inc == WORD_C)) begin
                    push      = 1'b1;
                    push_code = SYM_WORD;
                    state_d   = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pressed   = (state_q == PRESS);

    assign full      = (count == 3'd4);
    assign sym_valid = (count != 3'd0);
    assign sym_code  = fifo_mem[rd_ptr];
    assign do_pop    = sym_valid & sym_ready;
    assign do_push   = push & (~full | do_pop);

    // Symbol FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 2'b00;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= push_code;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag: a push arrived while full with no pop to make room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && full && !do_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule
